// File: rtl/bus_arb_pkg.sv
// Shared definitions for the bus response arbiter.
//   arb_state_e  : bus-cycle FSM states
//   owner_ext()  : owner code of the external I/O channel (N)
//   owner_none() : owner code meaning "no cycle in progress" (N+1)
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,   // waiting for a strobe
    WAIT,   // burning the owner's static wait states
    CHECK,  // polling the owner's ready, timeout running
    HOLD    // ready given, waiting for the strobes to release
  } arb_state_e;

  function automatic int owner_ext(input int num_sources);
    return num_sources;
  endfunction

  function automatic int owner_none(input int num_sources);
    return num_sources + 1;
  endfunction

endpackage

// File: rtl/bus_priority_encoder.sv
// Lowest-index-first priority encoder.
//   req_i   : request vector, bit 0 has highest priority
//   idx_o   : index of the lowest set bit (0 when nothing is set)
//   valid_o : at least one request bit is set
module bus_priority_encoder #(
  parameter int WIDTH     = 4,
  parameter int IDX_WIDTH = 3
) (
  input  logic [WIDTH-1:0]     req_i,
  output logic [IDX_WIDTH-1:0] idx_o,
  output logic                 valid_o
);

  always_comb begin
    idx_o   = '0;
    valid_o = |req_i;
    // Scan downwards so the lowest set index is the last one written.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IDX_WIDTH'(i);
    end
  end

endmodule

// File: rtl/bus_response_arbiter.sv
// Bus response arbiter: picks the responder of each CPU/DMA bus cycle,
// inserts its wait states, merges its ready into processor_ready and
// forces completion of cycles that never get a ready.
//   clock, reset_n          : bus clock, asynchronous active-low reset
//   bus_read_n, bus_write_n : cycle strobes, active low
//   source_select           : per-source address-decode claim
//   source_data             : packed read data, source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   source_ready            : per-source ready
//   source_wait_states      : packed static wait count per source
//   ext_data, ext_ready     : external I/O channel data and ready
//   timeout_clear           : clears the sticky timeout flag
//   data_out                : combinational read data from the latched owner
//   data_bus_direction      : 1 when the external channel drives the bus
//   owner                   : 0..N-1 source, N external, N+1 none
//   processor_ready         : registered ready to the CPU
//   bus_timeout             : one-cycle pulse on a forced completion
//   timeout_flag            : sticky timeout indicator
module bus_response_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NUM_SOURCES    = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int WAIT_WIDTH     = 3,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int OW            = $clog2(NUM_SOURCES + 2)
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             bus_read_n,
  input  logic                             bus_write_n,
  input  logic [NUM_SOURCES-1:0]           source_select,
  input  logic [NUM_SOURCES*DATA_WIDTH-1:0] source_data,
  input  logic [NUM_SOURCES-1:0]           source_ready,
  input  logic [NUM_SOURCES*WAIT_WIDTH-1:0] source_wait_states,
  input  logic [DATA_WIDTH-1:0]            ext_data,
  input  logic                             ext_ready,
  input  logic                             timeout_clear,
  output logic [DATA_WIDTH-1:0]            data_out,
  output logic                             data_bus_direction,
  output logic [OW-1:0]                    owner,
  output logic                             processor_ready,
  output logic                             bus_timeout,
  output logic                             timeout_flag
);

  localparam int            TW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [OW-1:0] OWNER_EXT  = OW'(owner_ext(NUM_SOURCES));
  localparam logic [OW-1:0] OWNER_NONE = OW'(owner_none(NUM_SOURCES));

  arb_state_e            state_q, state_d;
  logic [OW-1:0]         owner_q, owner_d;
  logic [WAIT_WIDTH-1:0] wcnt_q, wcnt_d;
  logic [TW-1:0]         tcnt_q, tcnt_d;
  logic                  ready_q, ready_d;
  logic                  tpulse_q, tpulse_d;
  logic                  flag_q, flag_d;

  logic                  strobe_active, strobes_idle;
  logic [OW-1:0]         enc_idx, cand_owner;
  logic                  enc_valid;
  logic [WAIT_WIDTH-1:0] cand_ws;
  logic                  sel_ready;
  logic                  timeout_event;

  assign strobe_active = !bus_read_n || !bus_write_n;
  assign strobes_idle  = bus_read_n && bus_write_n;

  bus_priority_encoder #(
    .WIDTH     (NUM_SOURCES),
    .IDX_WIDTH (OW)
  ) u_prio (
    .req_i   (source_select),
    .idx_o   (enc_idx),
    .valid_o (enc_valid)
  );

  // No claimant means the external channel owns the cycle, with no wait states.
  assign cand_owner = enc_valid ? enc_idx : OWNER_EXT;

  always_comb begin
    cand_ws = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (enc_valid && enc_idx == OW'(i))
        cand_ws = source_wait_states[i*WAIT_WIDTH +: WAIT_WIDTH];
    end
  end

  // Ready of the latched owner; "none" never reports ready.
  always_comb begin
    sel_ready = 1'b0;
    if (owner_q == OWNER_EXT) sel_ready = ext_ready;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (owner_q == OW'(i)) sel_ready = source_ready[i];
    end
  end

  // Unregistered data path; both strobes low counts as a write.
  always_comb begin
    data_out           = '0;
    data_bus_direction = 1'b0;
    if (!bus_read_n && bus_write_n) begin
      if (owner_q == OWNER_EXT) begin
        data_out           = ext_data;
        data_bus_direction = 1'b1;
      end
      for (int i = 0; i < NUM_SOURCES; i++) begin
        if (owner_q == OW'(i)) data_out = source_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // NOTE: every signal driven here gets a default first so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    wcnt_d        = wcnt_q;
    tcnt_d        = tcnt_q;
    ready_d       = ready_q;
    tpulse_d      = 1'b0;
    timeout_event = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (strobe_active) begin
          owner_d = cand_owner;
          wcnt_d  = cand_ws;
          tcnt_d  = '0;
          ready_d = 1'b0;
          state_d = (cand_ws != '0) ? WAIT : CHECK;
        end
      end
      WAIT: begin
        if (strobes_idle) begin
          state_d = IDLE;
          ready_d = 1'b1;
          owner_d = OWNER_NONE;
          tcnt_d  = '0;
        end else begin
          wcnt_d = wcnt_q - WAIT_WIDTH'(1);
          if (wcnt_q <= WAIT_WIDTH'(1)) state_d = CHECK;
        end
      end
      CHECK: begin
        if (strobes_idle) begin
          state_d = IDLE;
          ready_d = 1'b1;
          owner_d = OWNER_NONE;
          tcnt_d  = '0;
        end else if (sel_ready) begin
          ready_d = 1'b1;
          state_d = HOLD;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
          // Counter still holds the previous count, so T-1 marks the T-th cycle.
          if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            ready_d       = 1'b1;
            tpulse_d      = 1'b1;
            timeout_event = 1'b1;
            state_d       = HOLD;
          end
        end
      end
      HOLD: begin
        ready_d = 1'b1;
        if (strobes_idle) begin
          state_d = IDLE;
          owner_d = OWNER_NONE;
          tcnt_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A timeout in the same cycle as a clear leaves the flag set.
  assign flag_d = (flag_q && !timeout_clear) || timeout_event;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      owner_q  <= OWNER_NONE;
      wcnt_q   <= '0;
      tcnt_q   <= '0;
      ready_q  <= 1'b1;
      tpulse_q <= 1'b0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      wcnt_q   <= wcnt_d;
      tcnt_q   <= tcnt_d;
      ready_q  <= ready_d;
      tpulse_q <= tpulse_d;
      flag_q   <= flag_d;
    end
  end

  assign owner           = owner_q;
  assign processor_ready = ready_q;
  assign bus_timeout     = tpulse_q;
  assign timeout_flag    = flag_q;

endmodule

// File: tb/tb_bus_response_arbiter.sv
// Directed bench for bus_response_arbiter with NUM_SOURCES=4, DATA_WIDTH=8,
// WAIT_WIDTH=3, TIMEOUT_CYCLES=8. Inputs change on the falling edge and
// outputs are sampled there, half a period away from the active edge.
module tb_bus_response_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int WW = 3;
  localparam int TO = 8;
  localparam int OW = $clog2(N + 2);

  logic            clock = 1'b0;
  logic            reset_n;
  logic            bus_read_n, bus_write_n;
  logic [N-1:0]    source_select, source_ready;
  logic [N*DW-1:0] source_data;
  logic [N*WW-1:0] source_wait_states;
  logic [DW-1:0]   ext_data;
  logic            ext_ready, timeout_clear;
  logic [DW-1:0]   data_out;
  logic            data_bus_direction;
  logic [OW-1:0]   owner;
  logic            processor_ready, bus_timeout, timeout_flag;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  bus_response_arbiter #(
    .NUM_SOURCES    (N),
    .DATA_WIDTH     (DW),
    .WAIT_WIDTH     (WW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .bus_read_n         (bus_read_n),
    .bus_write_n        (bus_write_n),
    .source_select      (source_select),
    .source_data        (source_data),
    .source_ready       (source_ready),
    .source_wait_states (source_wait_states),
    .ext_data           (ext_data),
    .ext_ready          (ext_ready),
    .timeout_clear      (timeout_clear),
    .data_out           (data_out),
    .data_bus_direction (data_bus_direction),
    .owner              (owner),
    .processor_ready    (processor_ready),
    .bus_timeout        (bus_timeout),
    .timeout_flag       (timeout_flag)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One active edge, then back to the falling edge.
  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check_idle(input string tag);
    check({tag, " owner"}, 32'(owner), 5);
    check({tag, " ready"}, 32'(processor_ready), 1);
    check({tag, " data"}, 32'(data_out), 0);
    check({tag, " dir"}, 32'(data_bus_direction), 0);
  endtask

  initial begin
    reset_n            = 1'b0;
    bus_read_n         = 1'b1;
    bus_write_n        = 1'b1;
    source_select      = '0;
    source_ready       = '0;
    source_data        = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    // Wait states: src0=0, src1=2, src2=1, src3=3.
    source_wait_states = {3'd3, 3'd1, 3'd2, 3'd0};
    ext_data           = 8'h5E;
    ext_ready          = 1'b0;
    timeout_clear      = 1'b0;

    // ---- reset values ----
    #12;
    check_idle("rst");
    check("rst timeout", 32'(bus_timeout), 0);
    check("rst flag", 32'(timeout_flag), 0);
    @(negedge clock);
    reset_n = 1'b1;
    cyc();
    check_idle("post-rst idle");

    // ---- read, two claimants, src1 wins with 2 wait states ----
    bus_read_n    = 1'b0;
    source_select = 4'b0110;
    source_ready  = 4'b0010;
    cyc();  // E0
    check("t1 owner", 32'(owner), 1);
    check("t1 ready E0", 32'(processor_ready), 0);
    check("t1 data", 32'(data_out), 32'h B1);
    check("t1 dir", 32'(data_bus_direction), 0);
    source_select = 4'b0001;  // must be ignored after the latch
    cyc();  // E1
    check("t1 ready E1", 32'(processor_ready), 0);
    check("t1 owner held", 32'(owner), 1);
    cyc();  // E2
    check("t1 ready E2", 32'(processor_ready), 0);
    cyc();  // E3
    check("t1 ready E3", 32'(processor_ready), 1);
    check("t1 data E3", 32'(data_out), 32'h B1);
    bus_read_n = 1'b1;
    #1;
    check("t1 data after release", 32'(data_out), 0);
    cyc();
    check_idle("t1 end");

    // ---- read from external channel, ext_ready late ----
    source_select = '0;
    source_ready  = '0;
    bus_read_n    = 1'b0;
    cyc();  // E0
    check("t2 owner", 32'(owner), 4);
    check("t2 dir", 32'(data_bus_direction), 1);
    check("t2 data", 32'(data_out), 32'h 5E);
    for (int i = 1; i <= 5; i++) begin
      cyc();
      check($sformatf("t2 ready E%0d", i), 32'(processor_ready), 0);
    end
    ext_ready = 1'b1;
    cyc();  // E6
    check("t2 ready after ext", 32'(processor_ready), 1);
    check("t2 no timeout", 32'(bus_timeout), 0);
    bus_read_n = 1'b1;
    ext_ready  = 1'b0;
    cyc();
    check_idle("t2 end");

    // ---- timeout: src0, no ready ever ----
    source_select = 4'b0001;
    bus_read_n    = 1'b0;
    cyc();  // E0
    check("t3 owner", 32'(owner), 0);
    check("t3 data", 32'(data_out), 32'h A0);
    for (int i = 1; i < TO; i++) begin
      cyc();
      check($sformatf("t3 ready E%0d", i), 32'(processor_ready), 0);
      check($sformatf("t3 pulse E%0d", i), 32'(bus_timeout), 0);
    end
    cyc();  // E0+8
    check("t3 forced ready", 32'(processor_ready), 1);
    check("t3 pulse", 32'(bus_timeout), 1);
    check("t3 flag", 32'(timeout_flag), 1);
    cyc();
    check("t3 pulse once", 32'(bus_timeout), 0);
    check("t3 flag held", 32'(timeout_flag), 1);
    check("t3 hold ready", 32'(processor_ready), 1);
    bus_read_n = 1'b1;
    cyc();
    check_idle("t3 end");
    check("t3 flag sticky", 32'(timeout_flag), 1);
    timeout_clear = 1'b1;
    cyc();
    check("t3 flag cleared", 32'(timeout_flag), 0);
    timeout_clear = 1'b0;

    // ---- abort during WAIT (src3, 3 wait states) ----
    source_select = 4'b1000;
    bus_read_n    = 1'b0;
    cyc();  // E0
    check("t4 owner", 32'(owner), 3);
    check("t4 data", 32'(data_out), 32'h D3);
    cyc();  // E1
    check("t4 ready E1", 32'(processor_ready), 0);
    bus_read_n = 1'b1;
    cyc();  // abort edge
    check_idle("t4 abort");
    check("t4 no pulse", 32'(bus_timeout), 0);
    cyc();
    check("t4 still none", 32'(owner), 5);

    // ---- write to src2 (1 wait state) ----
    source_select = 4'b0100;
    source_ready  = 4'b0100;
    bus_write_n   = 1'b0;
    cyc();  // E0
    check("t5w owner", 32'(owner), 2);
    check("t5w data", 32'(data_out), 0);
    check("t5w dir", 32'(data_bus_direction), 0);
    check("t5w ready E0", 32'(processor_ready), 0);
    cyc();  // E1
    check("t5w ready E1", 32'(processor_ready), 0);
    cyc();  // E2
    check("t5w ready E2", 32'(processor_ready), 1);
    check("t5w data E2", 32'(data_out), 0);
    bus_write_n = 1'b1;
    cyc();
    check_idle("t5w end");

    // ---- both strobes low: write semantics ----
    bus_read_n  = 1'b0;
    bus_write_n = 1'b0;
    cyc();  // E0
    check("t5b owner", 32'(owner), 2);
    check("t5b data", 32'(data_out), 0);
    check("t5b dir", 32'(data_bus_direction), 0);
    cyc();  // E1
    check("t5b ready E1", 32'(processor_ready), 0);
    check("t5b data E1", 32'(data_out), 0);
    cyc();  // E2
    check("t5b ready E2", 32'(processor_ready), 1);
    bus_write_n = 1'b1;  // now a plain read of the same owner
    #1;
    check("t5b read data", 32'(data_out), 32'h C2);
    bus_read_n = 1'b1;
    cyc();
    check_idle("t5b end");

    // ---- reset asserted while in CHECK ----
    source_select = 4'b0001;
    source_ready  = '0;
    bus_read_n    = 1'b0;
    cyc();  // E0 -> CHECK
    cyc();  // one CHECK cycle
    check("t6 owner", 32'(owner), 0);
    check("t6 ready", 32'(processor_ready), 0);
    reset_n = 1'b0;
    #1;
    check_idle("t6 in reset");
    check("t6 pulse", 32'(bus_timeout), 0);
    @(negedge clock);
    reset_n = 1'b1;
    cyc();  // strobe still low: fresh cycle
    check("t6 rearb owner", 32'(owner), 0);
    check("t6 rearb ready", 32'(processor_ready), 0);
    source_ready = 4'b0001;
    cyc();
    check("t6 ready", 32'(processor_ready), 1);
    check("t6 no pulse", 32'(bus_timeout), 0);
    bus_read_n = 1'b1;
    cyc();
    check_idle("t6 end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
